// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory read in flight and
// buffers returned words in a 2-entry FIFO that feeds the decoder.
module instruction_fetch #(
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fsm_state
);

    typedef enum logic {REQ = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
    logic [ADDR_W-1:0] addr_q, addr_inc, issue_addr;
    logic              drop, drop_next;
    logic [1:0]        count, count_next, occupancy;
    logic              rd_ptr, wr_ptr;
    logic [31:0]       word_mem [2];
    logic [ADDR_W-1:0] pc_mem [2];
    logic              pop, push, issue, room;

    // Decoder handshake: a word transfers on any cycle where instr_valid and
    // instr_ready are both high; instr_valid never depends on instr_ready.
    assign instr_valid = (count != 2'd0);
    assign instruction = word_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign pop         = instr_valid && instr_ready;
    assign wr_ptr      = rd_ptr ^ (count == 2'd1);
    assign addr_inc    = addr_q + PC_ONE;
    assign fsm_state   = state;

    // Words held after this cycle's pop plus the read still in flight.
    assign occupancy = count - {1'b0, pop} + {1'b0, state == WAIT};
    assign room      = (occupancy < 2'd2);

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        drop_next     = drop;
        push          = 1'b0;
        issue         = 1'b0;
        issue_addr    = addr_q;
        case (state)
            REQ: begin
                if (reset && room && !redirect_valid) begin
                    issue      = 1'b1;
                    issue_addr = fetch_pc;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else if (!redirect_valid) begin
                        push          = 1'b1;
                        fetch_pc_next = addr_inc;
                        if (room) begin
                            issue      = 1'b1;
                            issue_addr = addr_inc;
                        end else begin
                            state_next = REQ;
                        end
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            default: state_next = REQ;
        endcase
        // A read still in flight at the redirect must be discarded on return.
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            if (state == WAIT && !imem_rvalid) drop_next = 1'b1;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = issue ? issue_addr : addr_q;

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, pop};
        if (redirect_valid) count_next = 2'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= REQ;
            fetch_pc    <= RESET_PC;
            addr_q      <= '0;
            drop        <= 1'b0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            word_mem[0] <= '0;
            word_mem[1] <= '0;
            pc_mem[0]   <= '0;
            pc_mem[1]   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            addr_q   <= imem_addr;
            drop     <= drop_next;
            count    <= count_next;
            if (pop) rd_ptr <= ~rd_ptr;
            if (push) begin
                word_mem[wr_ptr] <= imem_rdata;
                pc_mem[wr_ptr]   <= addr_q;
            end
        end
    end

endmodule
